// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS stream checker.
// Tap/seed pairs match the reference generators used on the bench.
package prbs_pkg;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  localparam logic [4:0] TAPS_5 = 5'h14;
  localparam logic [7:0] TAPS_8 = 8'hB8;
  localparam logic [4:0] SEED_5 = 5'h0F;
  localparam logic [7:0] SEED_8 = 8'h7F;

endpackage

// File: rtl/prbs_loss_mon.sv
// Lock-loss monitor: counts errors per window of valid beats and
// strobes loss on the beat that brings the window total to threshold.
module prbs_loss_mon
  import prbs_pkg::*;
#(
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic beat,
  input  logic err,
  output logic loss
);

  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  logic [BW-1:0] win_beats;
  logic [EW-1:0] win_err;
  logic          wrap;

  assign wrap = win_beats == BW'(WINDOW - 1);
  assign loss = beat && err &&
                (win_err == EW'(LOSS_THRESH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_beats <= '0;
      win_err   <= '0;
    end else if (beat) begin
      if (wrap) begin
        win_beats <= '0;
        win_err   <= '0;
      end else begin
        win_beats <= win_beats + 1'b1;
        win_err   <= win_err + EW'(err);
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising Fibonacci LFSR stream checker (hunt, lock, count).
// Optional PRBS_ZERO_GUARD_EN rejects an all-zero (stuck) line.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(TAPS_8),
  parameter int               LOCK_COUNT  = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 8,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  state_t           state;
  logic [WIDTH-1:0] history;
  logic [FW-1:0]    fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic             pred;
  logic             mism;
  logic             filled;
  logic             beat;
  logic             loss;
  logic             leave;
  logic             hold;

  assign pred   = ^(history & TAPS);
  assign mism   = in_bit ^ pred;
  assign filled = fill_cnt == FW'(WIDTH);
  assign beat   = in_valid && (state == LOCKED);

`ifdef PRBS_ZERO_GUARD_EN
  logic [FW-1:0] zero_run;

  assign hold  = history == '0;
  assign leave = loss ||
                 (beat && !in_bit &&
                  zero_run == FW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || state == HUNT) begin
      zero_run <= '0;
    end else if (in_valid) begin
      zero_run <= in_bit ? '0 : zero_run + 1'b1;
    end
  end
`else
  assign hold  = 1'b0;
  assign leave = loss;
`endif

  prbs_loss_mon #(
    .WINDOW     (WINDOW),
    .LOSS_THRESH(LOSS_THRESH)
  ) u_loss (
    .clk (clk),
    .rst (rst),
    .clr (state == HUNT),
    .beat(beat),
    .err (mism),
    .loss(loss)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      history   <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          HUNT: begin
            history <= {history[WIDTH-2:0], in_bit};
            if (!filled) begin
              fill_cnt <= fill_cnt + 1'b1;
            end else if (mism || hold) begin
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            // flywheel: keep our own prediction so errors never corrupt history
            history   <= {history[WIDTH-2:0], pred};
            err_pulse <= mism;
            if (leave) begin
              state     <= HUNT;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
      if (clear_cnt) begin
        err_count <= '0;
      end else if (beat && mism && !(&err_count)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
